// File: rtl/age_ordered_reservation_station.sv
// Reservation station for one execution unit: buffers waiting instructions,
// snoops every CDB for operand wakeup and issues the oldest ready entry.
module age_ordered_reservation_station #(
    parameter int OPERANDS      = 2,
    parameter int OPERAND_WIDTH = 32,
    parameter int RS_OFFSET     = 0,
    parameter int RS_DEPTH      = 8,
    parameter int RS_ID_WIDTH   = 5,
    parameter int CDB_COUNT     = 2,
    parameter type CONTROL_TYPE = logic [7:0]
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    flush,
    input  logic                                    take_valid,
    output logic                                    take_ready,
    input  logic [OPERANDS-1:0]                     op_value_valid_in,
    input  logic [OPERANDS-1:0][RS_ID_WIDTH-1:0]    op_rs_id_in,
    input  logic [OPERANDS-1:0][OPERAND_WIDTH-1:0]  op_value_in,
    input  CONTROL_TYPE                             control_in,
    output logic [RS_ID_WIDTH-1:0]                  id_taken,
    input  logic [CDB_COUNT-1:0]                    cdb_valid,
    input  logic [CDB_COUNT-1:0][RS_ID_WIDTH-1:0]   cdb_rs_id,
    input  logic [CDB_COUNT-1:0][OPERAND_WIDTH-1:0] cdb_value,
    output logic                                    output_valid,
    input  logic                                    output_ready,
    output logic [OPERANDS-1:0][OPERAND_WIDTH-1:0]  op_value_out,
    output CONTROL_TYPE                             control_out,
    output logic [RS_ID_WIDTH-1:0]                  op_rs_id_out,
    output logic [$clog2(RS_DEPTH+1)-1:0]           occupancy
);
    localparam int AGE_W = $clog2(RS_DEPTH);
    localparam int OCC_W = $clog2(RS_DEPTH + 1);

    typedef logic [OPERANDS-1:0][RS_ID_WIDTH-1:0]   tags_t;
    typedef logic [OPERANDS-1:0][OPERAND_WIDTH-1:0] vals_t;
    typedef logic [AGE_W-1:0]                       age_t;

    logic [RS_DEPTH-1:0] valid_q, valid_d;
    CONTROL_TYPE         ctrl_q [RS_DEPTH];
    CONTROL_TYPE         ctrl_d [RS_DEPTH];
    logic [OPERANDS-1:0] rdy_q  [RS_DEPTH];
    logic [OPERANDS-1:0] rdy_d  [RS_DEPTH];
    tags_t               tag_q  [RS_DEPTH];
    tags_t               tag_d  [RS_DEPTH];
    vals_t               val_q  [RS_DEPTH];
    vals_t               val_d  [RS_DEPTH];
    age_t                age_q  [RS_DEPTH];
    age_t                age_d  [RS_DEPTH];
    logic [OCC_W-1:0]    occ_q, occ_d;

    logic                free_found;
    logic [AGE_W-1:0]    free_idx;
    logic                iss_found;
    logic [AGE_W-1:0]    iss_idx;
    age_t                iss_age;
    logic                alloc;
    logic                issue;
    logic [OPERANDS-1:0] new_rdy;
    vals_t               new_val;

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (!valid_q[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = AGE_W'(i);
            end
        end
    end

    // Ages are unique, so the largest age among ready entries is the oldest.
    always_comb begin
        iss_found = 1'b0;
        iss_idx   = '0;
        iss_age   = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (valid_q[i] && (&rdy_q[i]) &&
                (!iss_found || age_q[i] > iss_age)) begin
                iss_found = 1'b1;
                iss_idx   = AGE_W'(i);
                iss_age   = age_q[i];
            end
        end
    end

    assign take_ready   = free_found && !flush;
    assign output_valid = iss_found && !flush;
    assign alloc        = take_valid && take_ready;
    assign issue        = output_valid && output_ready;
    assign occupancy    = occ_q;

    always_comb begin
        id_taken = RS_ID_WIDTH'(RS_OFFSET);
        if (free_found) begin
            id_taken = RS_ID_WIDTH'(int'(free_idx) + RS_OFFSET);
        end
    end

    always_comb begin
        op_value_out = '0;
        control_out  = '0;
        op_rs_id_out = RS_ID_WIDTH'(RS_OFFSET);
        if (output_valid) begin
            op_value_out = val_q[iss_idx];
            control_out  = ctrl_q[iss_idx];
            op_rs_id_out = RS_ID_WIDTH'(int'(iss_idx) + RS_OFFSET);
        end
    end

    // Same-cycle capture; scanning buses high to low lets bus 0 win.
    always_comb begin
        new_rdy = op_value_valid_in;
        new_val = op_value_in;
        for (int o = 0; o < OPERANDS; o++) begin
            for (int c = CDB_COUNT - 1; c >= 0; c--) begin
                if (!op_value_valid_in[o] && cdb_valid[c] &&
                    cdb_rs_id[c] == op_rs_id_in[o]) begin
                    new_rdy[o] = 1'b1;
                    new_val[o] = cdb_value[c];
                end
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        rdy_d   = rdy_q;
        tag_d   = tag_q;
        val_d   = val_q;
        age_d   = age_q;
        occ_d   = occ_q + OCC_W'(alloc) - OCC_W'(issue);
        for (int i = 0; i < RS_DEPTH; i++) begin
            for (int o = 0; o < OPERANDS; o++) begin
                for (int c = CDB_COUNT - 1; c >= 0; c--) begin
                    if (valid_q[i] && !rdy_q[i][o] && cdb_valid[c] &&
                        cdb_rs_id[c] == tag_q[i][o]) begin
                        rdy_d[i][o] = 1'b1;
                        val_d[i][o] = cdb_value[c];
                    end
                end
            end
            if (valid_q[i] && alloc) begin
                age_d[i] = age_d[i] + age_t'(1);
            end
            if (valid_q[i] && issue && age_q[i] > iss_age) begin
                age_d[i] = age_d[i] - age_t'(1);
            end
        end
        if (issue) begin
            valid_d[iss_idx] = 1'b0;
            age_d[iss_idx]   = '0;
        end
        if (alloc) begin
            valid_d[free_idx] = 1'b1;
            ctrl_d[free_idx]  = control_in;
            rdy_d[free_idx]   = new_rdy;
            tag_d[free_idx]   = op_rs_id_in;
            val_d[free_idx]   = new_val;
            age_d[free_idx]   = '0;
        end
        if (flush) begin
            valid_d = '0;
            occ_d   = '0;
            for (int i = 0; i < RS_DEPTH; i++) begin
                age_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            occ_q   <= '0;
            for (int i = 0; i < RS_DEPTH; i++) begin
                ctrl_q[i] <= '0;
                rdy_q[i]  <= '0;
                tag_q[i]  <= '0;
                val_q[i]  <= '0;
                age_q[i]  <= '0;
            end
        end else begin
            valid_q <= valid_d;
            occ_q   <= occ_d;
            ctrl_q  <= ctrl_d;
            rdy_q   <= rdy_d;
            tag_q   <= tag_d;
            val_q   <= val_d;
            age_q   <= age_d;
        end
    end
endmodule

// File: tb/tb_age_ordered_reservation_station.sv
// Directed and random checks of the reservation station against an
// age-ordered queue model (front of queue = oldest entry).
module tb_age_ordered_reservation_station;
    localparam int OFF = 8;

    typedef struct packed {
        int              id;
        logic [7:0]      ctrl;
        logic [1:0]      rdy;
        logic [1:0][4:0] tag;
        logic [1:0][31:0] val;
    } ent_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             flush;
    logic             take_valid;
    logic             take_ready;
    logic [1:0]       op_value_valid_in;
    logic [1:0][4:0]  op_rs_id_in;
    logic [1:0][31:0] op_value_in;
    logic [7:0]       control_in;
    logic [4:0]       id_taken;
    logic [1:0]       cdb_valid;
    logic [1:0][4:0]  cdb_rs_id;
    logic [1:0][31:0] cdb_value;
    logic             output_valid;
    logic             output_ready;
    logic [1:0][31:0] op_value_out;
    logic [7:0]       control_out;
    logic [4:0]       op_rs_id_out;
    logic [3:0]       occupancy;

    int   total = 0;
    int   bad   = 0;
    ent_t q[$];

    age_ordered_reservation_station #(
        .OPERANDS(2), .OPERAND_WIDTH(32), .RS_OFFSET(OFF), .RS_DEPTH(8),
        .RS_ID_WIDTH(5), .CDB_COUNT(2), .CONTROL_TYPE(logic [7:0])
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .take_valid(take_valid), .take_ready(take_ready),
        .op_value_valid_in(op_value_valid_in), .op_rs_id_in(op_rs_id_in),
        .op_value_in(op_value_in), .control_in(control_in),
        .id_taken(id_taken), .cdb_valid(cdb_valid), .cdb_rs_id(cdb_rs_id),
        .cdb_value(cdb_value), .output_valid(output_valid),
        .output_ready(output_ready), .op_value_out(op_value_out),
        .control_out(control_out), .op_rs_id_out(op_rs_id_out),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic check_now(output int k, output bit ov, output bit tr,
                             output int fid);
        bit [7:0] used;
        ent_t     s;
        used = '0;
        foreach (q[j]) used[q[j].id - OFF] = 1'b1;
        fid = OFF;
        for (int j = 7; j >= 0; j--) if (!used[j]) fid = OFF + j;
        tr = (q.size() < 8) && !flush;
        k = -1;
        foreach (q[j]) if (k < 0 && q[j].rdy == 2'b11) k = j;
        ov = (k >= 0) && !flush;
        s = '0;
        if (ov) s = q[k];
        chk("take_ready", take_ready, tr);
        chk("id_taken", id_taken, fid);
        chk("output_valid", output_valid, ov);
        chk("occupancy", occupancy, q.size());
        chk("op_rs_id_out", op_rs_id_out, ov ? s.id : OFF);
        chk("op0_out", op_value_out[0], s.val[0]);
        chk("op1_out", op_value_out[1], s.val[1]);
        chk("control_out", control_out, s.ctrl);
    endtask

    task automatic step();
        int   k, fid;
        bit   ov, tr, al, is;
        ent_t ne, e;
        #1;
        check_now(k, ov, tr, fid);
        al = take_valid && tr;
        is = ov && output_ready;
        ne = '0;
        ne.id = fid;
        ne.ctrl = control_in;
        for (int o = 0; o < 2; o++) begin
            ne.rdy[o] = op_value_valid_in[o];
            ne.tag[o] = op_rs_id_in[o];
            ne.val[o] = op_value_in[o];
            for (int c = 0; c < 2; c++)
                if (!ne.rdy[o] && cdb_valid[c] && cdb_rs_id[c] == op_rs_id_in[o]) begin
                    ne.rdy[o] = 1'b1;
                    ne.val[o] = cdb_value[c];
                end
        end
        @(posedge clk);
        if (flush) begin
            q.delete();
        end else begin
            foreach (q[j]) begin
                e = q[j];
                for (int o = 0; o < 2; o++)
                    for (int c = 0; c < 2; c++)
                        if (!e.rdy[o] && cdb_valid[c] && cdb_rs_id[c] == e.tag[o]) begin
                            e.rdy[o] = 1'b1;
                            e.val[o] = cdb_value[c];
                        end
                q[j] = e;
            end
            if (is) q.delete(k);
            if (al) q.push_back(ne);
        end
        @(negedge clk);
    endtask

    task automatic idle();
        flush = 1'b0;
        take_valid = 1'b0;
        output_ready = 1'b0;
        op_value_valid_in = 2'b11;
        op_rs_id_in = '0;
        op_value_in = '0;
        control_in = '0;
        cdb_valid = '0;
        cdb_rs_id = '0;
        cdb_value = '0;
    endtask

    task automatic give(input logic [7:0] ctl, input logic [1:0] vv,
                        input logic [4:0] t0, input logic [31:0] v0,
                        input logic [31:0] v1);
        take_valid = 1'b1;
        control_in = ctl;
        op_value_valid_in = vv;
        op_rs_id_in[0] = t0;
        op_rs_id_in[1] = 5'd0;
        op_value_in[0] = v0;
        op_value_in[1] = v1;
    endtask

    initial begin
        int  k, fid;
        bit  ov, tr;
        idle();
        #1;
        check_now(k, ov, tr, fid);
        @(negedge clk);
        rst = 1'b1;

        // Fill with ready entries, then drain oldest first.
        for (int i = 0; i < 8; i++) begin
            give(8'(8'h10 + i), 2'b11, 5'd0, $urandom, $urandom);
            step();
        end
        idle();
        #1;
        chk("full_take_ready", take_ready, 1'b0);
        chk("full_occ", occupancy, 8);
        step();
        output_ready = 1'b1;
        for (int i = 0; i < 9; i++) step();

        // A waits on tag 20, B ready; B goes first.
        idle();
        give(8'hA0, 2'b10, 5'd20, 32'h0, 32'h1111);
        step();
        give(8'hB0, 2'b11, 5'd0, 32'h2222, 32'h3333);
        step();
        idle();
        cdb_valid = 2'b01;
        cdb_rs_id[0] = 5'd20;
        cdb_value[0] = 32'h55;
        output_ready = 1'b1;
        #1;
        chk("b_first", op_rs_id_out, OFF + 1);
        step();
        idle();
        output_ready = 1'b1;
        #1;
        chk("a_id", op_rs_id_out, OFF);
        chk("a_op0", op_value_out[0], 32'h55);
        step();

        // Capture at allocation from cdb1.
        idle();
        give(8'hC0, 2'b10, 5'd3, 32'h0, 32'h4);
        cdb_valid = 2'b10;
        cdb_rs_id[1] = 5'd3;
        cdb_value[1] = 32'hAB;
        step();
        idle();
        output_ready = 1'b1;
        #1;
        chk("c_valid", output_valid, 1'b1);
        chk("c_op0", op_value_out[0], 32'hAB);
        step();

        // Two buses with the same tag: bus 0 wins.
        idle();
        give(8'hD0, 2'b10, 5'd7, 32'h0, 32'h9);
        step();
        idle();
        cdb_valid = 2'b11;
        cdb_rs_id[0] = 5'd7;
        cdb_rs_id[1] = 5'd7;
        cdb_value[0] = 32'd1;
        cdb_value[1] = 32'd2;
        step();
        idle();
        output_ready = 1'b1;
        #1;
        chk("d_op0", op_value_out[0], 32'd1);
        step();

        // Full station: issue with take_valid, no same-cycle reuse.
        idle();
        for (int i = 0; i < 8; i++) begin
            give(8'(8'h20 + i), 2'b11, 5'd0, $urandom, $urandom);
            step();
        end
        give(8'h99, 2'b11, 5'd0, 32'h77, 32'h88);
        output_ready = 1'b1;
        #1;
        chk("full_no_take", take_ready, 1'b0);
        step();
        output_ready = 1'b0;
        #1;
        chk("reuse_ready", take_ready, 1'b1);
        chk("reuse_id", id_taken, OFF);
        step();
        idle();
        output_ready = 1'b1;
        for (int i = 0; i < 9; i++) step();

        // Flush overrides take and issue.
        idle();
        for (int i = 0; i < 5; i++) begin
            give(8'(8'h30 + i), 2'b11, 5'd0, $urandom, $urandom);
            step();
        end
        flush = 1'b1;
        take_valid = 1'b1;
        output_ready = 1'b1;
        #1;
        chk("flush_take_ready", take_ready, 1'b0);
        chk("flush_out_valid", output_valid, 1'b0);
        step();
        idle();
        #1;
        chk("flush_occ", occupancy, 0);
        step();

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            take_valid = 1'($urandom_range(0, 1));
            control_in = 8'($urandom);
            for (int o = 0; o < 2; o++) begin
                op_value_valid_in[o] = ($urandom_range(0, 2) != 0);
                op_rs_id_in[o] = 5'($urandom_range(0, 7));
                op_value_in[o] = $urandom;
            end
            for (int c = 0; c < 2; c++) begin
                cdb_valid[c] = ($urandom_range(0, 3) == 0);
                cdb_rs_id[c] = 5'($urandom_range(0, 7));
                cdb_value[c] = $urandom;
            end
            output_ready = ($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 39) == 0);
            step();
        end

        // Reset mid-run takes effect without a clock edge.
        idle();
        for (int i = 0; i < 3; i++) begin
            give(8'(8'h40 + i), 2'b11, 5'd0, $urandom, $urandom);
            step();
        end
        idle();
        rst = 1'b0;
        q.delete();
        #1;
        check_now(k, ov, tr, fid);
        @(negedge clk);
        rst = 1'b1;
        give(8'h50, 2'b11, 5'd0, 32'hCAFE, 32'hF00D);
        step();
        idle();
        output_ready = 1'b1;
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
